spsram_64x16: RTL and testbench
===============================

// Module: spsram_64x16
// PURPOSE
//  Single-port synchronous SRAM, 64 words x 16 bits, one shared address port.
//  Serves as a ping-pong buffer in the 8x8 matrix-transpose stage of the 2-D FHT core.
//  - Writes one row-major 8x8 block.
//  - Reads it back column-major.
//  Control inputs are active-low (chip select, write enable), matching the ASIC SRAM macro convention.
// PARAMETERS
//  AW     6    address width
//  DW     16   data width
//  DEPTH  64   number of words (= 2**AW)
// PORTS
//  sclk   in   1    clock; all activity on rising edge
//  rstn   in   1    asynchronous active-low reset
//  addr   in   AW   word address, sampled at sclk rise
//  din    in   DW   write data
//  dout   out  DW   registered read data
//  en     in   1    chip select, ACTIVE-LOW (0 = access this cycle)
//  we     in   1    write enable, ACTIVE-LOW (0 = write, 1 = read when en=0)
// BEHAVIOUR
//  - Reset: dout <= 0 asynchronously on rstn=0 and held while low.
//    - Memory array is NOT reset; unwritten words read as undefined (X in simulation).
//  - Access decode at each sclk rise (rstn=1):
//    - en=0, we=0 -> mem[addr] <= din; dout holds its previous value (no-change mode).
//    - en=0, we=1 -> dout <= mem[addr]; one-cycle read latency, data valid after the edge.
//    - en=1 -> idle: no write, dout holds, we/addr/din ignored.
//  - Back-to-back accesses allowed every cycle; no handshake, no busy state.
//  - Write then read of the same address on the next cycle returns the new data.
//  - Addresses 0..63 cover the full space; no out-of-range case, no wrap logic needed.
//  - dout changes only on a read cycle (or on reset); hold behaviour on writes is modified only by the option below.
//  - Reset asserted mid-operation:
//    - dout clears immediately.
//    - An access on the same edge as reset assertion is dropped.
//    - Stored contents are retained.
//  - X/Z on en or we in simulation: the write is suppressed, dout is driven X (error flag for the bench).
// CONFIGURATION
//  SPSRAM_WRITE_THRU_EN
//   - Defined: write-first mode. On a write cycle dout <= din, and mem[addr] is updated on the same edge.
//   - Undefined (default): no-change mode; dout holds on write cycles.
//   - Read and idle behaviour are identical in both modes.
// TESTING
//  1. Reset: rstn=0 with random inputs -> dout==16'h0000 throughout; after release dout stays 0 until the first read.
//  2. Fill/readback:
//     - Write mem[i]=16'hA500+i for i=0..63 (en=0, we=0, one per cycle).
//     - Then read i=0..63 -> dout==16'hA500+i one cycle after each address.
//  3. Transpose order: read addresses {i[2:0],i[5:3]} for i=0..63 after step 2 -> dout==16'hA500+{i[2:0],i[5:3]}.
//  4. Idle/hold:
//     - Read addr 5 -> dout==16'hA505.
//     - Then 10 cycles en=1 with we=0, addr=5, din=16'hFFFF -> dout stays 16'hA505; mem[5] unchanged on re-read.
//  5. Write/read same addr:
//     - Write 16'h1234 to addr 63, read addr 63 next cycle -> dout==16'h1234.
//     - dout during the write cycle: old value (default) or 16'h1234 (SPSRAM_WRITE_THRU_EN).
//  6. Mid-operation reset: pulse rstn low during a read stream -> dout==0 at once; next read of addr 7 returns 16'hA507 (contents kept).

Source files
------------

// File: rtl/spsram_64x16.sv
// 64x16 single-port synchronous SRAM with active-low controls and registered read data.
// Optional write-first mode under `define SPSRAM_WRITE_THRU_EN; default is no-change on writes.
module spsram_64x16 #(
  parameter int AW    = 6,
  parameter int DW    = 16,
  parameter int DEPTH = 64
) (
  input  logic          sclk,
  input  logic          rstn,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  input  logic          en,
  input  logic          we
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] dout_q, dout_d;
  logic          wr_en;

  // Unknown control suppresses the write and poisons dout so a bad stimulus is visible.
  always_comb begin
    dout_d = dout_q;
    wr_en  = 1'b0;
    case (en)
      1'b1: ;
      1'b0: begin
        case (we)
          1'b0: begin
            wr_en = 1'b1;
`ifdef SPSRAM_WRITE_THRU_EN
            dout_d = din;
`endif
          end
          1'b1:    dout_d = mem[addr];
          default: dout_d = 'x;
        endcase
      end
      default: dout_d = 'x;
    endcase
  end

  // Array is deliberately not reset; an edge that coincides with reset drops the write.
  always_ff @(posedge sclk) begin
    if (rstn && wr_en) mem[addr] <= din;
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_spsram_64x16.sv
// Self-checking bench for spsram_64x16: directed steps plus random traffic against an array model.
module tb_spsram_64x16;

  logic        sclk = 1'b0;
  logic        rstn;
  logic [5:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        en, we;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem_m [64];
  logic [15:0] exp_q;

  spsram_64x16 dut (
    .sclk (sclk),
    .rstn (rstn),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .en   (en),
    .we   (we)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge: apply inputs, let one rising edge pass, update model, compare.
  task automatic cycle(input logic e, input logic w, input logic [5:0] a,
                       input logic [15:0] d, input string tag);
    en = e; we = w; addr = a; din = d;
    @(posedge sclk); #1;
    if (!rstn) exp_q = 16'h0000;
    else if (!e && !w) begin
      mem_m[a] = d;
`ifdef SPSRAM_WRITE_THRU_EN
      exp_q = d;
`endif
    end else if (!e && w) exp_q = mem_m[a];
    check(tag, dout, exp_q);
    @(negedge sclk);
  endtask

  initial begin
    logic [5:0] iv, ta;
    exp_q = 16'h0000;
    rstn = 1'b0; en = 1'b1; we = 1'b1; addr = '0; din = '0;
    #2;
    check("reset_async", dout, 16'h0000);
    @(negedge sclk);

    // Reset held with random activity: nothing may leak through.
    for (int i = 0; i < 6; i++)
      cycle(1'($urandom), 1'($urandom), 6'($urandom), 16'($urandom), "reset_hold");
    rstn = 1'b1;
    cycle(1'b1, 1'b1, 6'd0, 16'h0, "post_reset_idle");
    check("post_reset_zero", dout, 16'h0000);

    for (int i = 0; i < 64; i++)
      cycle(1'b0, 1'b0, 6'(i), 16'hA500 + 16'(i), "fill");
    for (int i = 0; i < 64; i++) begin
      cycle(1'b0, 1'b1, 6'(i), 16'h0, "readback");
      check("readback_const", dout, 16'hA500 + 16'(i));
    end

    for (int i = 0; i < 64; i++) begin
      iv = 6'(i);
      ta = {iv[2:0], iv[5:3]};
      cycle(1'b0, 1'b1, ta, 16'h0, "transpose");
      check("transpose_const", dout, 16'hA500 + 16'(ta));
    end

    cycle(1'b0, 1'b1, 6'd5, 16'h0, "hold_read");
    check("hold_read_const", dout, 16'hA505);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 1'b0, 6'd5, 16'hFFFF, "idle_hold");
    check("idle_hold_const", dout, 16'hA505);
    cycle(1'b0, 1'b1, 6'd5, 16'h0, "idle_reread");
    check("idle_reread_const", dout, 16'hA505);

    cycle(1'b0, 1'b0, 6'd63, 16'h1234, "wr63_dout");
`ifdef SPSRAM_WRITE_THRU_EN
    check("wr63_dout_const", dout, 16'h1234);
`else
    check("wr63_dout_const", dout, 16'hA505);
`endif
    cycle(1'b0, 1'b1, 6'd63, 16'h0, "rd63");
    check("rd63_const", dout, 16'h1234);

    // Reset in the middle of a read stream; the access under reset is dropped.
    cycle(1'b0, 1'b1, 6'd10, 16'h0, "stream_a");
    cycle(1'b0, 1'b1, 6'd11, 16'h0, "stream_b");
    rstn = 1'b0; #1;
    exp_q = 16'h0000;
    check("midreset_async", dout, 16'h0000);
    @(negedge sclk);
    cycle(1'b0, 1'b0, 6'd7, 16'hDEAD, "midreset_drop");
    rstn = 1'b1;
    cycle(1'b0, 1'b1, 6'd7, 16'h0, "after_reset_rd7");
    check("after_reset_rd7_const", dout, 16'hA507);

    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) == 0), 1'($urandom), 6'($urandom), 16'($urandom), "random");
    for (int i = 0; i < 64; i++)
      cycle(1'b0, 1'b1, 6'(i), 16'h0, "final_sweep");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
